// File: rtl/sc_regbank_general.sv
// General-purpose register bank: r0 reads zero, one write port, two combinational read ports,
// and a one-register-per-clock clear sweep. Optional macro SC_REGBANK_BYPASS_EN forwards write data to reads.
module sc_regbank_general #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH     = 5,
  parameter int NUMREG        = 32
)(
  input  logic                     SC_RegBANK_CLOCK_50,
  input  logic                     SC_RegBANK_RESET_InLow,
  input  logic                     SC_RegBANK_Write_InLow,
  input  logic [ADDRWIDTH-1:0]     SC_RegBANK_WriteAddr_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUS_In,
  input  logic [ADDRWIDTH-1:0]     SC_RegBANK_ReadAddrA_In,
  input  logic [ADDRWIDTH-1:0]     SC_RegBANK_ReadAddrB_In,
  input  logic                     SC_RegBANK_Clear_InLow,
  output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSA_Out,
  output logic [DATAWIDTH_BUS-1:0] SC_RegBANK_DataBUSB_Out,
  output logic                     SC_RegBANK_Busy_Out,
  output logic                     SC_RegBANK_WriteError_Out
);

  // state    | meaning
  // ST_IDLE  | normal reads/writes, clear request accepted here
  // ST_CLEAR | zeroing r_ptr = 1 .. NUMREG-1, one per edge; all writes rejected

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [ADDRWIDTH:0]   LP_NUMREG = (ADDRWIDTH+1)'(NUMREG);
  localparam logic [ADDRWIDTH-1:0] LP_LAST   = ADDRWIDTH'(NUMREG - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDRWIDTH-1:0]     r_ptr;
  logic [DATAWIDTH_BUS-1:0] r_regs [NUMREG];
  logic                     r_wr_err;

  logic                     w_wr_req;
  logic                     w_clr_req;
  logic                     w_waddr_oob;
  logic                     w_wr_accept;
  logic                     w_wr_reject;
  logic                     w_a_valid;
  logic                     w_b_valid;
  logic                     w_busy;
  logic [DATAWIDTH_BUS-1:0] w_rd_a;
  logic [DATAWIDTH_BUS-1:0] w_rd_b;

  assign w_wr_req    = ~SC_RegBANK_Write_InLow;
  assign w_clr_req   = ~SC_RegBANK_Clear_InLow;
  assign w_waddr_oob = ({1'b0, SC_RegBANK_WriteAddr_In} >= LP_NUMREG);

  // Clear wins over a simultaneous write; address 0 is dropped without flagging.
  assign w_wr_accept = SC_RegBANK_RESET_InLow & w_wr_req & (r_state == ST_IDLE) & ~w_clr_req
                     & ~w_waddr_oob & (SC_RegBANK_WriteAddr_In != '0);
  assign w_wr_reject = w_wr_req & ((r_state == ST_CLEAR) | w_clr_req | w_waddr_oob);

  always_ff @(negedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
    if (!SC_RegBANK_RESET_InLow) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_clr_req) w_state_next = ST_CLEAR;
      ST_CLEAR: if (r_ptr == LP_LAST) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_CLEAR);
  end

  always_ff @(negedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
    if (!SC_RegBANK_RESET_InLow) begin
      for (int i = 0; i < NUMREG; i++) r_regs[i] <= '0;
      r_ptr    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      if (w_wr_reject) r_wr_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_clr_req) begin
            r_ptr <= ADDRWIDTH'(1);
          end else if (w_wr_accept) begin
            r_regs[SC_RegBANK_WriteAddr_In] <= SC_RegBANK_DataBUS_In;
          end
        end
        ST_CLEAR: begin
          r_regs[r_ptr] <= '0;
          r_ptr         <= r_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_a_valid = (SC_RegBANK_ReadAddrA_In != '0) && ({1'b0, SC_RegBANK_ReadAddrA_In} < LP_NUMREG);
  assign w_b_valid = (SC_RegBANK_ReadAddrB_In != '0) && ({1'b0, SC_RegBANK_ReadAddrB_In} < LP_NUMREG);

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (w_a_valid) w_rd_a = r_regs[SC_RegBANK_ReadAddrA_In];
    if (w_b_valid) w_rd_b = r_regs[SC_RegBANK_ReadAddrB_In];
`ifdef SC_REGBANK_BYPASS_EN
    if (w_wr_accept && (SC_RegBANK_ReadAddrA_In == SC_RegBANK_WriteAddr_In)) w_rd_a = SC_RegBANK_DataBUS_In;
    if (w_wr_accept && (SC_RegBANK_ReadAddrB_In == SC_RegBANK_WriteAddr_In)) w_rd_b = SC_RegBANK_DataBUS_In;
`else
`endif
  end

  assign SC_RegBANK_DataBUSA_Out   = w_rd_a;
  assign SC_RegBANK_DataBUSB_Out   = w_rd_b;
  assign SC_RegBANK_Busy_Out       = w_busy;
  assign SC_RegBANK_WriteError_Out = r_wr_err;

endmodule

// File: doc/sc_regbank_general.md
# sc_regbank_general

Parametrised general-purpose register bank: NUMREG registers of DATAWIDTH_BUS bits with one write port and two asynchronous read ports. Register 0 is hard-wired to zero. A hardware clear sequencer zeroes the whole bank without a reset, one register per clock. The bank supplies both ALU operands and takes the ALU/memory result in the datapath, replacing discrete single general registers.

## Interface
- DATAWIDTH_BUS, 32, register and bus width
- ADDRWIDTH, 5, address width
- NUMREG, 32, number of registers; 2 ≤ NUMREG ≤ 2^ADDRWIDTH

- SC_RegBANK_CLOCK_50  input  1  single clock; all state updates on the falling edge
- SC_RegBANK_RESET_InLow  input  1  reset, asynchronous, active-low
- SC_RegBANK_Write_InLow  input  1  write request, active-low
- SC_RegBANK_WriteAddr_In  input  ADDRWIDTH  write address
- SC_RegBANK_DataBUS_In  input  DATAWIDTH_BUS  write data
- SC_RegBANK_ReadAddrA_In  input  ADDRWIDTH  read address, port A
- SC_RegBANK_ReadAddrB_In  input  ADDRWIDTH  read address, port B
- SC_RegBANK_Clear_InLow  input  1  clear-sweep request, active-low
- SC_RegBANK_DataBUSA_Out  output  DATAWIDTH_BUS  port A read data
- SC_RegBANK_DataBUSB_Out  output  DATAWIDTH_BUS  port B read data
- SC_RegBANK_Busy_Out  output  1  high while the clear sweep runs
- SC_RegBANK_WriteError_Out  output  1  sticky flag for rejected writes

## Operation
- FSM states: IDLE, CLEAR. Sweep pointer is ADDRWIDTH bits wide.
- IDLE: on a falling edge with Clear_InLow=0, go to CLEAR and set pointer=1. Otherwise, a write with Write_InLow=0 and 1 ≤ WriteAddr < NUMREG stores DataBUS_In.
- CLEAR: each falling edge sets reg[pointer]=0 and increments the pointer. On the edge that clears reg[NUMREG-1], return to IDLE. Clear_InLow is ignored while in CLEAR.
- Write to address 0 is dropped silently. It is not an error.
- Write rejected as an error, setting WriteError to 1 on that edge:
  - WriteAddr ≥ NUMREG
  - any write while in CLEAR
  - a write in IDLE on the same edge as an accepted clear request (clear has priority)
- WriteError is sticky. Only reset clears it.
- Reads are combinational. Address 0 or an address ≥ NUMREG reads 0. Otherwise the port outputs the stored register. Both ports may use the same address.
- Busy_Out = (state == CLEAR), driven combinationally from the state register.

## Timing
- Reset (asynchronous, RESET_InLow=0):
  - all registers, pointer and WriteError go to 0; state goes to IDLE
  - both data outputs 0, Busy_Out 0, WriteError_Out 0
  - takes effect immediately, including in the middle of a sweep, which is abandoned
- Release of reset is sampled at the next falling edge.
- Write latency: data is visible on the read ports immediately after the accepting falling edge, with zero wait states.
- Clear sweep:
  - Busy rises right after the falling edge that accepts the request.
  - It stays high for exactly NUMREG-1 falling edges.
  - After the edge that clears reg[NUMREG-1], Busy is low and the bank is all zero.
  - A write presented on the first edge with Busy low is accepted.
- Registers not yet reached by the sweep keep their values and stay readable mid-sweep.

## Configuration
- Macro: SC_REGBANK_BYPASS_EN.
- When defined: a read port whose address equals WriteAddr outputs DataBUS_In combinationally before the edge, provided the write would be accepted: Write_InLow=0, state IDLE, no clear request, 1 ≤ WriteAddr < NUMREG. The write itself is unchanged.
- When undefined: read ports always show stored contents, and new data appears only after the falling edge.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and 0x12345678 to r31 -> A=r5 reads 0xDEADBEEF and B=r31 reads 0x12345678 after each write edge; WriteError=0.
- Write 0xFFFFFFFF to r0 -> r0 reads 0, WriteError stays 0. With NUMREG=24, write to r30 -> reads 0, WriteError=1 until reset.
- Fill r1..r31, pulse Clear_InLow low for one edge:
  - Busy is high for exactly 31 edges.
  - Mid-sweep at edge 10, r20 still holds its value.
  - At the end all registers read 0 and Busy=0.
- Write r7 during CLEAR, and separately write r7 on the same edge as the clear request -> r7 unchanged by the write, WriteError=1.
- Assert RESET_InLow=0 at sweep edge 5 -> all outputs 0 immediately. After release, a write of 0xA5A5A5A5 to r3 is accepted on the first edge.
- With SC_REGBANK_BYPASS_EN: drive a write of 0x0000CAFE to r9 with A=r9 -> A shows 0x0000CAFE before the edge. Without the macro: A shows the old r9 value until the edge.
